// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks the program counter, reads program memory
// and hands one instruction byte per fetch to the decoder.
module instr_fetch #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] NOP_INSTR = 8'h80
) (
    input  logic       clock,
    input  logic       reset,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] databus,
    output logic       instr_valid,
    input  logic       pc_set,
    input  logic       cond_true,
    input  logic [7:0] jump_target,
    input  logic       halt,
    output logic [7:0] pc,
    output logic       running
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        FETCH  = 5'b00010,
        ISSUE  = 5'b00100,
        EXEC   = 5'b01000,
        HALTED = 5'b10000
    } state_t;

    state_t     state_q;
    state_t     state_nxt;
    logic [7:0] pc_q;
    logic [7:0] pc_nxt;
    logic [7:0] ir_q;
    logic       armed_q;
    logic       take_jump;
    logic       fetch_done;

    assign fetch_done = (state_q == FETCH) && mem_ack;
    assign take_jump  = pc_set && cond_true;
    assign pc_nxt     = take_jump ? jump_target : pc_q + 8'd1;

    // armed_q holds the sequencer in IDLE for the first edge after release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            ir_q <= NOP_INSTR;
        end else begin
            if (fetch_done)
                ir_q <= mem_data;
            if (state_q == EXEC)
                pc_q <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (armed_q && !halt) state_nxt = FETCH;
            FETCH:   if (mem_ack) state_nxt = ISSUE;
            ISSUE:   state_nxt = EXEC;
            EXEC:    state_nxt = halt ? HALTED : FETCH;
            HALTED:  if (!halt) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        databus     = NOP_INSTR;
        instr_valid = 1'b0;
        running     = 1'b0;
        unique case (state_q)
            IDLE:    ;
            FETCH: begin
                mem_req = 1'b1;
                running = 1'b1;
            end
            ISSUE: begin
                databus     = ir_q;
                instr_valid = 1'b1;
                running     = 1'b1;
            end
            EXEC:    running = 1'b1;
            HALTED:  ;
            default: ;
        endcase
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;

    a_onehot: assert property (
        @(posedge clock) disable iff (!reset) $onehot(state_q));

    a_req_stable: assert property (
        @(posedge clock) disable iff (!reset)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for the
// straight-line fetch stream, then sequences for waits, jumps, halt, reset.
module tb_instr_fetch;

    logic       clock;
    logic       reset;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] databus;
    logic       instr_valid;
    logic       pc_set;
    logic       cond_true;
    logic [7:0] jump_target;
    logic       halt;
    logic [7:0] pc;
    logic       running;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .databus     (databus),
        .instr_valid (instr_valid),
        .pc_set      (pc_set),
        .cond_true   (cond_true),
        .jump_target (jump_target),
        .halt        (halt),
        .pc          (pc),
        .running     (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n;
        logic       hlt;
        logic       ack;
        logic [7:0] data;
        logic       e_req;
        logic [7:0] e_addr;
        logic [7:0] e_db;
        logic       e_v;
        logic       e_run;
    } vec_t;

    vec_t vt[11];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_fetch(input string tag, input logic [7:0] addr,
                            input logic [7:0] data, input int waits,
                            input logic ps, input logic ct,
                            input logic [7:0] tgt, input logic hlt);
        halt = hlt;
        chk({tag, " req"}, {7'd0, mem_req}, 8'd1);
        chk({tag, " addr"}, mem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0;
            step();
            chk({tag, " wait req"}, {7'd0, mem_req}, 8'd1);
            chk({tag, " wait addr"}, mem_addr, addr);
            chk({tag, " wait valid"}, {7'd0, instr_valid}, 8'd0);
        end
        mem_ack  = 1'b1;
        mem_data = data;
        step();
        mem_ack = 1'b0;
        chk({tag, " issue valid"}, {7'd0, instr_valid}, 8'd1);
        chk({tag, " issue data"}, databus, data);
        chk({tag, " issue req"}, {7'd0, mem_req}, 8'd0);
        pc_set      = ps;
        cond_true   = ct;
        jump_target = tgt;
        step();
        chk({tag, " exec valid"}, {7'd0, instr_valid}, 8'd0);
        chk({tag, " exec nop"}, databus, 8'h80);
        step();
        pc_set    = 1'b0;
        cond_true = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = 8'h00;
        pc_set      = 1'b0;
        cond_true   = 1'b0;
        jump_target = 8'h00;
        halt        = 1'b0;

        //         rst hlt ack data   req addr  db     v  run
        vt[0]  = '{1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 8'h00, 8'h80, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'h41, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 8'h42, 1'b1, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 8'h01, 8'h42, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 8'h02, 8'h80, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 8'h02, 8'h43, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h43, 1'b0, 8'h02, 8'h80, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'h80, 1'b0, 1'b1};

        step();
        step();
        chk("rst req", {7'd0, mem_req}, 8'd0);
        chk("rst addr", mem_addr, 8'h00);
        chk("rst pc", pc, 8'h00);
        chk("rst db", databus, 8'h80);
        chk("rst valid", {7'd0, instr_valid}, 8'd0);
        chk("rst run", {7'd0, running}, 8'd0);

        for (int i = 0; i < 11; i++) begin
            reset    = vt[i].rst_n;
            halt     = vt[i].hlt;
            mem_ack  = vt[i].ack;
            mem_data = vt[i].data;
            step();
            chk($sformatf("vec%0d req", i), {7'd0, mem_req}, {7'd0, vt[i].e_req});
            chk($sformatf("vec%0d addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d db", i), databus, vt[i].e_db);
            chk($sformatf("vec%0d valid", i), {7'd0, instr_valid},
                {7'd0, vt[i].e_v});
            chk($sformatf("vec%0d run", i), {7'd0, running}, {7'd0, vt[i].e_run});
        end

        do_fetch("wait4", 8'h03, 8'hC0, 4, 1'b1, 1'b1, 8'h10, 1'b0);
        do_fetch("jmp", 8'h10, 8'hC0, 0, 1'b1, 1'b1, 8'h05, 1'b0);
        chk("jmp addr", mem_addr, 8'h05);
        do_fetch("back", 8'h05, 8'hC0, 0, 1'b1, 1'b1, 8'h10, 1'b0);
        do_fetch("nojmp", 8'h10, 8'hC0, 0, 1'b1, 1'b0, 8'h05, 1'b0);
        chk("nojmp addr", mem_addr, 8'h11);
        do_fetch("toff", 8'h11, 8'hC0, 0, 1'b1, 1'b1, 8'hFF, 1'b0);
        do_fetch("wrap", 8'hFF, 8'h41, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("wrap pc", pc, 8'h00);
        do_fetch("self", 8'h00, 8'hC0, 0, 1'b1, 1'b1, 8'h00, 1'b0);
        do_fetch("to07", 8'h00, 8'hC0, 0, 1'b1, 1'b1, 8'h07, 1'b0);

        do_fetch("halt", 8'h07, 8'h41, 2, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("halt pc", pc, 8'h08);
        chk("halt run", {7'd0, running}, 8'd0);
        chk("halt req", {7'd0, mem_req}, 8'd0);
        mem_ack = 1'b1;
        step();
        step();
        chk("halted pc", pc, 8'h08);
        chk("halted req", {7'd0, mem_req}, 8'd0);
        mem_ack = 1'b0;
        halt    = 1'b0;
        step();
        chk("resume req", {7'd0, mem_req}, 8'd1);
        chk("resume addr", mem_addr, 8'h08);
        chk("resume run", {7'd0, running}, 8'd1);

        mem_ack  = 1'b1;
        mem_data = 8'h42;
        reset    = 1'b0;
        #1;
        chk("arst req", {7'd0, mem_req}, 8'd0);
        chk("arst addr", mem_addr, 8'h00);
        step();
        chk("arst valid", {7'd0, instr_valid}, 8'd0);
        chk("arst db", databus, 8'h80);
        reset = 1'b1;
        step();
        chk("rel1 req", {7'd0, mem_req}, 8'd0);
        chk("rel1 valid", {7'd0, instr_valid}, 8'd0);
        step();
        chk("rel2 req", {7'd0, mem_req}, 8'd1);
        chk("rel2 addr", mem_addr, 8'h00);
        chk("rel2 valid", {7'd0, instr_valid}, 8'd0);
        step();
        chk("rel3 valid", {7'd0, instr_valid}, 8'd1);
        chk("rel3 db", databus, 8'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, the program address fetched first after reset.
REQ-002 Parameter NOP_INSTR, default 8'h80 (copy reg0->reg0), the byte driven on databus whenever no instruction is being issued.
REQ-003 clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces all state to reset values immediately.
REQ-005 mem_req  output  1  program-memory read request.
REQ-006 mem_addr  output  8  program-memory read address.
REQ-007 mem_ack  input  1  memory read-data-valid strobe; ignored while mem_req=0.
REQ-008 mem_data  input  8  program-memory read data; sampled only when mem_req=1 and mem_ack=1.
REQ-009 databus  output  8  instruction byte presented to the instruction decoder (opcode [7:6], arg [5:0]).
REQ-010 instr_valid  output  1  high for exactly the cycle in which databus carries a fetched instruction.
REQ-011 pc_set  input  1  decoder's registered jump-request flag (opcode 2'b11).
REQ-012 cond_true  input  1  condition unit result for the current Cond instruction.
REQ-013 jump_target  input  8  branch destination address.
REQ-014 halt  input  1  level request to stop fetching.
REQ-015 pc  output  8  address of the instruction currently fetched or executing.
REQ-016 running  output  1  high in every state except IDLE and HALTED.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, ISSUE, EXEC, HALTED, with exactly one state active each cycle.
REQ-018 IDLE -> FETCH when halt=0; otherwise stay IDLE.
REQ-019 FETCH: mem_req=1, mem_addr=pc, both held stable until mem_ack=1; on mem_ack, latch mem_data into the instruction register -> ISSUE.
REQ-020 mem_ack in the first FETCH cycle is legal; the minimum FETCH duration is 1 cycle.
REQ-021 ISSUE: databus=instruction register and instr_valid=1 for exactly one cycle -> EXEC.
REQ-022 Outside ISSUE, databus SHALL equal NOP_INSTR and instr_valid SHALL be 0.
REQ-023 EXEC (1 cycle): when pc_set=1 and cond_true=1, pc <= jump_target; otherwise pc <= pc+1, modulo 256 (8'hFF -> 8'h00, no flag).
REQ-024 EXEC -> HALTED when halt=1, else -> FETCH; the pc update in REQ-023 occurs in both cases.
REQ-025 HALTED: mem_req=0; -> FETCH on the first cycle halt=0; pc is unchanged.
REQ-026 halt asserted in FETCH or ISSUE SHALL NOT abort the fetch; it takes effect at the next EXEC.
REQ-027 Fetch-to-fetch latency with mem_ack in the first cycle: 3 cycles (FETCH, ISSUE, EXEC).
REQ-028 A jump to its own address (jump_target == pc) SHALL refetch the same address; no special casing.
REQ-029 mem_req SHALL be high only in FETCH.

Reset
REQ-030 While reset=0: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, databus=NOP_INSTR, instr_valid=0, running=0, instruction register=NOP_INSTR.
REQ-031 Reset asserted mid-fetch SHALL drop mem_req in the same cycle, and an ack arriving during reset SHALL be discarded.
REQ-032 The first mem_req after reset release SHALL be no earlier than the second rising clock edge.

Verification
REQ-033 Release reset with halt=0 and mem_ack tied high, memory returning 0x41,0x42,0x43 -> mem_addr 00,01,02; databus 41/42/43 with instr_valid, each spaced 3 cycles apart; NOP (0x80) on databus otherwise.
REQ-034 Memory acks after 4 wait cycles -> mem_req and mem_addr held stable for 5 cycles; instr_valid pulses once per fetch.
REQ-035 At pc=0x10, fetch 0xC0 with pc_set=1, cond_true=1, jump_target=0x05 -> next mem_addr=0x05; repeat with cond_true=0 -> next mem_addr=0x11.
REQ-036 pc=0xFF with no jump -> next mem_addr=0x00.
REQ-037 Assert halt during FETCH at pc=0x07 -> current instruction still issued, pc becomes 0x08, state HALTED with running=0 and mem_req=0; deassert halt -> fetch at 0x08.
REQ-038 Pulse reset low while mem_req=1 and mem_ack=1 -> no instr_valid pulse; the next fetch is at RESET_PC.
